// File: rtl/heichips25_project_mux.sv
`default_nettype none
// ============================================================================
// Module   : heichips25_project_mux
// Purpose  : Runtime-selectable multi-project slot for one set of
//            Tiny-Tapeout-style pads. Exactly one project owns the pads.
//            A switch first drains the pads to zero, then holds the incoming
//            project in reset before handing it the pads.
// Ports    :
//   clk, rst                 clock, asynchronous active-high reset
//   ena                      global harness enable
//   sel_valid, sel_id        slot selection request
//   sel_ready                high while a request can be accepted (ACTIVE)
//   sel_err                  one-cycle pulse for an out-of-range request
//   active_id                slot currently owning the pads
//   proj_ena, proj_rst_n     per-slot enable / active-low reset
//   proj_uo_out, proj_uio_out, proj_uio_oe
//                            flattened project outputs, slot k = [8k+7:8k]
//   uo_out, uio_out, uio_oe  registered pad outputs
// Revision : 1.0 - initial release
// ============================================================================
module heichips25_project_mux #(
  parameter int NUM_PROJECTS    = 3,
  parameter int DRAIN_CYCLES    = 2,
  parameter int RST_CYCLES      = 4,
  parameter int DEFAULT_PROJECT = 0,
  parameter int SEL_W           = (NUM_PROJECTS > 2) ? $clog2(NUM_PROJECTS) : 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      ena,
  input  logic                      sel_valid,
  input  logic [SEL_W-1:0]          sel_id,
  output logic                      sel_ready,
  output logic                      sel_err,
  output logic [SEL_W-1:0]          active_id,
  output logic [NUM_PROJECTS-1:0]   proj_ena,
  output logic [NUM_PROJECTS-1:0]   proj_rst_n,
  input  logic [8*NUM_PROJECTS-1:0] proj_uo_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_out,
  input  logic [8*NUM_PROJECTS-1:0] proj_uio_oe,
  output logic [7:0]                uo_out,
  output logic [7:0]                uio_out,
  output logic [7:0]                uio_oe
);

  localparam int C_CNT_MAX = (DRAIN_CYCLES > RST_CYCLES) ? DRAIN_CYCLES : RST_CYCLES;
  localparam int C_CNT_W   = (C_CNT_MAX > 1) ? $clog2(C_CNT_MAX + 1) : 1;

  localparam logic [C_CNT_W-1:0] c_drain_last = C_CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] c_rst_last   = C_CNT_W'(RST_CYCLES - 1);
  localparam logic [C_CNT_W-1:0] c_cnt_one    = C_CNT_W'(1);
  localparam logic [SEL_W:0]     c_num_proj   = (SEL_W + 1)'(NUM_PROJECTS);
  localparam logic [SEL_W-1:0]   c_default    = SEL_W'(DEFAULT_PROJECT);

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_RESET  = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [C_CNT_W-1:0]      r_cnt;
  logic [C_CNT_W-1:0]      w_cnt_nxt;
  logic [SEL_W-1:0]        r_active;
  logic [SEL_W-1:0]        w_active_nxt;
  logic [SEL_W-1:0]        r_target;
  logic [SEL_W-1:0]        w_target_nxt;
  logic                    w_err_nxt;

  logic                    r_sel_ready;
  logic                    r_sel_err;
  logic [NUM_PROJECTS-1:0] r_proj_ena;
  logic [NUM_PROJECTS-1:0] r_proj_rst_n;
  logic [7:0]              r_uo_out;
  logic [7:0]              r_uio_out;
  logic [7:0]              r_uio_oe;

  logic [7:0]              w_uo_slot  [NUM_PROJECTS];
  logic [7:0]              w_uio_slot [NUM_PROJECTS];
  logic [7:0]              w_oe_slot  [NUM_PROJECTS];
  logic [7:0]              w_uo_sel;
  logic [7:0]              w_uio_sel;
  logic [7:0]              w_oe_sel;
  logic [NUM_PROJECTS-1:0] w_onehot_nxt;
  logic                    w_pads_live;

  // Split the flattened project buses into per-slot bytes.
  generate
    for (genvar k = 0; k < NUM_PROJECTS; k++) begin : g_slot
      assign w_uo_slot[k]  = proj_uo_out[8*k +: 8];
      assign w_uio_slot[k] = proj_uio_out[8*k +: 8];
      assign w_oe_slot[k]  = proj_uio_oe[8*k +: 8];
    end
  endgenerate

  // Slot mux driven by the current owner; the owner never changes while
  // the pads are live, so using the registered id is safe.
  always_comb begin
    w_uo_sel  = '0;
    w_uio_sel = '0;
    w_oe_sel  = '0;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      if (r_active == SEL_W'(k)) begin
        w_uo_sel  = w_uo_slot[k];
        w_uio_sel = w_uio_slot[k];
        w_oe_sel  = w_oe_slot[k];
      end
    end
  end

  // Next-state logic. The accept condition uses the ACTIVE state directly,
  // which is exactly what sel_ready reflects.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_active_nxt = r_active;
    w_target_nxt = r_target;
    w_err_nxt    = 1'b0;
    case (r_state)
      ST_ACTIVE: begin
        if (sel_valid) begin
          if ({1'b0, sel_id} >= c_num_proj) begin
            w_err_nxt = 1'b1;
          end else if (sel_id != r_active) begin
            w_state_nxt  = ST_DRAIN;
            w_cnt_nxt    = '0;
            w_target_nxt = sel_id;
          end
        end
      end
      ST_DRAIN: begin
        if (r_cnt == c_drain_last) begin
          w_state_nxt  = ST_RESET;
          w_cnt_nxt    = '0;
          w_active_nxt = r_target;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      ST_RESET: begin
        if (r_cnt == c_rst_last) begin
          w_state_nxt = ST_ACTIVE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt + c_cnt_one;
        end
      end
      default: begin
        w_state_nxt = ST_RESET;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  always_comb begin
    w_onehot_nxt = '0;
    for (int k = 0; k < NUM_PROJECTS; k++) begin
      w_onehot_nxt[k] = (w_active_nxt == SEL_W'(k));
    end
  end

  // Pads carry data only when ACTIVE both before and after the edge: the
  // accepting edge already blanks them, and the first ACTIVE cycle still
  // shows zero so the new project gets one clean cycle out of reset.
  assign w_pads_live = (r_state == ST_ACTIVE) && (w_state_nxt == ST_ACTIVE) && ena;

  // All outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_RESET;
      r_cnt        <= '0;
      r_active     <= c_default;
      r_target     <= c_default;
      r_sel_ready  <= 1'b0;
      r_sel_err    <= 1'b0;
      r_proj_ena   <= '0;
      r_proj_rst_n <= '0;
      r_uo_out     <= '0;
      r_uio_out    <= '0;
      r_uio_oe     <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_cnt        <= w_cnt_nxt;
      r_active     <= w_active_nxt;
      r_target     <= w_target_nxt;
      r_sel_ready  <= (w_state_nxt == ST_ACTIVE);
      r_sel_err    <= w_err_nxt;
      r_proj_ena   <= ((w_state_nxt == ST_ACTIVE) && ena) ? w_onehot_nxt : '0;
      // The outgoing project stays out of reset through DRAIN.
      r_proj_rst_n <= (w_state_nxt == ST_RESET) ? '0 : w_onehot_nxt;
      r_uo_out     <= w_pads_live ? w_uo_sel  : 8'h00;
      r_uio_out    <= w_pads_live ? w_uio_sel : 8'h00;
      r_uio_oe     <= w_pads_live ? w_oe_sel  : 8'h00;
    end
  end

  assign sel_ready  = r_sel_ready;
  assign sel_err    = r_sel_err;
  assign active_id  = r_active;
  assign proj_ena   = r_proj_ena;
  assign proj_rst_n = r_proj_rst_n;
  assign uo_out     = r_uo_out;
  assign uio_out    = r_uio_out;
  assign uio_oe     = r_uio_oe;

endmodule
`default_nettype wire
